// File: rtl/spram_bank.sv
`default_nettype none
// ============================================================================
//  Module   : spram_bank
//  Purpose  : BANKS x (16K x W) SPRAM array behind one byte-addressed port with
//             ready handshake, registered read steering and per-bank STANDBY.
//             Define SPRAM_OUTREG_EN for an extra read-data output register.
//  Revision : 1.0
// ============================================================================

// Behavioural stand-in with the SB_SPRAM256KA pin semantics (16K x 16,
// nibble write masks, registered read port).
module spram_bank_prim (
    input  logic        clk,
    input  logic [13:0] i_addr,
    input  logic [15:0] i_din,
    input  logic [3:0]  i_maskwren,
    input  logic        i_wren,
    input  logic        i_cs,
    input  logic        i_standby,
    input  logic        i_sleep,
    input  logic        i_poweroff,
    output logic [15:0] o_dout
);
    logic [15:0] r_mem [16384];
    logic [15:0] r_dout;
    logic [15:0] w_wword;
    logic        w_en;

    assign w_en = i_cs & ~i_standby & ~i_sleep & i_poweroff;

    always_comb begin
        w_wword = r_mem[i_addr];
        for (int n = 0; n < 4; n++) begin
            if (i_maskwren[n]) begin
                w_wword[4*n +: 4] = i_din[4*n +: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            if (i_wren) begin
                r_mem[i_addr] <= w_wword;
            end else begin
                r_dout <= r_mem[i_addr];
            end
        end
    end

    assign o_dout = r_dout;
endmodule

module spram_bank #(
    parameter int W        = 32,
    parameter int BANKS    = 2,
    parameter int IDLE_CYC = 64,
    parameter int WAKE_CYC = 2,
    // 16 bits of in-bank byte address plus the bank field
    parameter int AW       = 16 + $clog2(BANKS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ren,
    input  logic             wen,
    input  logic [AW-1:0]    addr,
    input  logic [W-1:0]     wdata,
    input  logic [W/8-1:0]   wmask,
    output logic             ready,
    output logic [W-1:0]     rdata,
    output logic             rd_valid,
    output logic [BANKS-1:0] sleeping
);
    localparam int NPRIM  = W / 16;
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int ICW    = (IDLE_CYC > 0) ? $clog2(IDLE_CYC + 1) : 1;
    localparam int WCW    = (WAKE_CYC > 0) ? $clog2(WAKE_CYC + 1) : 1;

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_STANDBY = 2'd1,
        ST_WAKE    = 2'd2
    } bank_state_t;

    logic [BANK_W-1:0]          w_bank;
    logic [BANKS-1:0]           w_active;
    logic [BANKS-1:0][W-1:0]    w_bank_rd;
    logic                       w_req;
    logic                       w_acc;
    logic                       w_rd;
    logic                       w_unused_addr;
    logic [W-1:0]               w_mux;
    logic                       r_rv1;
    logic [BANK_W-1:0]          r_rsel;

    generate
        if (BANKS > 1) begin : g_multi_bank
            assign w_bank = addr[AW-1:16];
        end else begin : g_single_bank
            assign w_bank = '0;
        end
    endgenerate

    assign w_unused_addr = ^addr[1:0];
    assign w_req         = ren | wen;
    assign ready         = w_active[w_bank];
    assign w_acc         = w_req & ready;
    // a write wins over a simultaneous read
    assign w_rd          = w_acc & ren & ~wen;

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        bank_state_t    r_state;
        bank_state_t    w_state_nx;
        logic [ICW-1:0] r_idle;
        logic [ICW-1:0] w_idle_nx;
        logic [ICW-1:0] w_idle_inc;
        logic [WCW-1:0] r_wake;
        logic [WCW-1:0] w_wake_nx;
        logic           w_hit;
        logic           w_sel;

        assign w_hit      = w_req & (w_bank == BANK_W'(b));
        assign w_sel      = w_acc & (w_bank == BANK_W'(b));
        assign w_idle_inc = (r_idle == ICW'(IDLE_CYC)) ? r_idle : r_idle + ICW'(1);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= ST_ACTIVE;
                r_idle  <= '0;
                r_wake  <= '0;
            end else begin
                r_state <= w_state_nx;
                r_idle  <= w_idle_nx;
                r_wake  <= w_wake_nx;
            end
        end

        always_comb begin
            w_state_nx = r_state;
            w_idle_nx  = r_idle;
            w_wake_nx  = r_wake;
            case (r_state)
                ST_ACTIVE: begin
                    if (w_hit) begin
                        w_idle_nx = '0;
                    end else if ((IDLE_CYC != 0) && (w_idle_inc == ICW'(IDLE_CYC))) begin
                        w_state_nx = ST_STANDBY;
                        w_idle_nx  = '0;
                    end else begin
                        w_idle_nx = w_idle_inc;
                    end
                end
                ST_STANDBY: begin
                    if (w_hit) begin
                        w_state_nx = ST_WAKE;
                        w_wake_nx  = WCW'(WAKE_CYC);
                    end
                end
                ST_WAKE: begin
                    // leave on the cycle the count would hit zero so the
                    // held request is taken in the first ACTIVE cycle
                    if (r_wake <= WCW'(1)) begin
                        w_state_nx = ST_ACTIVE;
                        w_wake_nx  = '0;
                        w_idle_nx  = '0;
                    end else begin
                        w_wake_nx = r_wake - WCW'(1);
                    end
                end
                default: begin
                    w_state_nx = ST_ACTIVE;
                end
            endcase
        end

        assign w_active[b] = (r_state == ST_ACTIVE);
        assign sleeping[b] = (r_state == ST_STANDBY);

        for (genvar p = 0; p < NPRIM; p++) begin : g_prim
            spram_bank_prim u_prim (
                .clk        (clk),
                .i_addr     (addr[15:2]),
                .i_din      (wdata[16*p +: 16]),
                .i_maskwren ({wmask[2*p+1], wmask[2*p+1], wmask[2*p], wmask[2*p]}),
                .i_wren     (wen),
                .i_cs       (w_sel),
                .i_standby  (r_state == ST_STANDBY),
                .i_sleep    (1'b0),
                .i_poweroff (1'b1),
                .o_dout     (w_bank_rd[b][16*p +: 16])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rv1  <= 1'b0;
            r_rsel <= '0;
        end else begin
            r_rv1 <= w_rd;
            if (w_rd) begin
                r_rsel <= w_bank;
            end
        end
    end

    assign w_mux = w_bank_rd[r_rsel];

`ifdef SPRAM_OUTREG_EN
    logic         r_rv2;
    logic [W-1:0] r_rdata2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rv2    <= 1'b0;
            r_rdata2 <= '0;
        end else begin
            r_rv2 <= r_rv1;
            if (r_rv1) begin
                r_rdata2 <= w_mux;
            end
        end
    end

    assign rd_valid = r_rv2 & ~rst;
    assign rdata    = r_rdata2;
`else
    logic [W-1:0] r_hold;
    logic         w_rv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else if (r_rv1) begin
            r_hold <= w_mux;
        end
    end

    // rst cancels a strobe already in flight
    assign w_rv     = r_rv1 & ~rst;
    assign rd_valid = w_rv;
    assign rdata    = w_rv ? w_mux : r_hold;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spram_bank.sv
`default_nettype none
// Directed self-checking bench for spram_bank (W=32, BANKS=2, IDLE_CYC=4, WAKE_CYC=2).
module tb_spram_bank;
    localparam int W     = 32;
    localparam int BANKS = 2;
    localparam int IDLE  = 4;
    localparam int WAKE  = 2;
    localparam int AW    = 17;
`ifdef SPRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          ren;
    logic          wen;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wmask;
    logic          ready;
    logic [31:0]   rdata;
    logic          rd_valid;
    logic [1:0]    sleeping;
    int            n_cmp  = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    spram_bank #(
        .W        (W),
        .BANKS    (BANKS),
        .IDLE_CYC (IDLE),
        .WAKE_CYC (WAKE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ren      (ren),
        .wen      (wen),
        .addr     (addr),
        .wdata    (wdata),
        .wmask    (wmask),
        .ready    (ready),
        .rdata    (rdata),
        .rd_valid (rd_valid),
        .sleeping (sleeping)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, hold it until ready (bounded), return just after the accepting edge.
    task automatic do_req(input string tag, input logic r, input logic w, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] m);
        int waits;
        ren = r; wen = w; addr = a; wdata = d; wmask = m;
        #1;
        waits = 0;
        while (!ready && waits < 16) begin
            tick();
            waits++;
        end
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        tick();
        ren = 1'b0;
        wen = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
        do_req(tag, 1'b1, 1'b0, a, 32'd0, 4'h0);
        for (int s = 0; s < LAT - 1; s++) begin
            chk({tag, "_early_valid"}, 32'(rd_valid), 32'd0);
            tick();
        end
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk({tag, "_data"}, rdata, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; ren = 1'b0; wen = 1'b0;
        addr = '0; wdata = '0; wmask = '0;
        tick(); tick(); tick();
        rst = 1'b0;
        #1;
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_sleeping", 32'(sleeping), 32'd0);
        chk("reset_rdata", rdata, 32'd0);

        // bank steering while both banks are still awake after reset
        do_req("wr_b0", 1'b0, 1'b1, 17'h00000, 32'h1, 4'hF);
        do_req("wr_b1", 1'b0, 1'b1, 17'h10000, 32'h2, 4'hF);
        ren = 1'b1; addr = 17'h00000;
        #1;
        chk("b2b_ready0", 32'(ready), 32'd1);
        tick();
        addr = 17'h10000;
        #1;
        chk("b2b_ready1", 32'(ready), 32'd1);
        for (int s = 0; s < 4; s++) begin
            if (s == LAT - 1) begin
                chk("b2b_valid0", 32'(rd_valid), 32'd1);
                chk("b2b_data0", rdata, 32'h1);
            end else if (s == LAT) begin
                chk("b2b_valid1", 32'(rd_valid), 32'd1);
                chk("b2b_data1", rdata, 32'h2);
            end else begin
                chk("b2b_idle_valid", 32'(rd_valid), 32'd0);
            end
            tick();
            if (s == 0) ren = 1'b0;
            #1;
        end

        // basic write/read and hold of rdata afterwards
        do_req("wr_dead", 1'b0, 1'b1, 17'h00004, 32'hDEADBEEF, 4'hF);
        rd_check("rd_dead", 17'h00004, 32'hDEADBEEF);
        tick();
        chk("hold_valid", 32'(rd_valid), 32'd0);
        chk("hold_rdata", rdata, 32'hDEADBEEF);

        // byte mask
        do_req("wr_mask_full", 1'b0, 1'b1, 17'h0000C, 32'h11223344, 4'hF);
        do_req("wr_mask_part", 1'b0, 1'b1, 17'h0000C, 32'hAABBCCDD, 4'b0101);
        rd_check("rd_mask", 17'h0000C, 32'h11BB33DD);

        // mask-0 write is an access that clears the idle count but keeps data
        do_req("wr_mask0", 1'b0, 1'b1, 17'h00004, 32'h12345678, 4'h0);
        tick(); tick(); tick();
        chk("idle3_sleep0", 32'(sleeping[0]), 32'd0);
        tick();
        chk("idle4_sleeping", 32'(sleeping), 32'b11);

        // wake-up read of bank 0; bank 1 must stay asleep
        ren = 1'b1; addr = 17'h00004;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("wake_ready_low", 32'(ready), 32'd0);
            if (i == 1) chk("wake_sleeping", 32'(sleeping), 32'b10);
            tick();
        end
        chk("wake_ready_up", 32'(ready), 32'd1);
        chk("wake_no_early_valid", 32'(rd_valid), 32'd0);
        tick();
        ren = 1'b0;
        for (int s = 0; s < LAT - 1; s++) begin
            chk("wake_early_valid", 32'(rd_valid), 32'd0);
            tick();
        end
        chk("wake_valid", 32'(rd_valid), 32'd1);
        chk("wake_data", rdata, 32'hDEADBEEF);

        // simultaneous ren & wen: write only
        do_req("rw_both", 1'b1, 1'b1, 17'h00008, 32'h55, 4'hF);
        chk("rw_no_valid0", 32'(rd_valid), 32'd0);
        tick();
        chk("rw_no_valid1", 32'(rd_valid), 32'd0);
        rd_check("rw_read", 17'h00008, 32'h55);

        // reset the cycle after a read accept
        do_req("rst_rd", 1'b1, 1'b0, 17'h00004, 32'd0, 4'h0);
        rst = 1'b1;
        #1;
        chk("rst_valid_during", 32'(rd_valid), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_valid_after", 32'(rd_valid), 32'd0);
        chk("rst_sleeping", 32'(sleeping), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        tick();
        chk("rst_valid_late", 32'(rd_valid), 32'd0);
        rd_check("rst_retained", 17'h00004, 32'hDEADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
